// File: rtl/pool_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pool_pkg
//  Description : Shared types and constants for the 2x2 pooling element.
//                DATA_W : pixel width (signed, Q5.10 by default)
//                FRAC_W : fractional bits of the default pixel format
//                WIN    : pixels per pooling window (2x2)
//  Revision    : 1.0  initial release
// ============================================================================
package pool_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 10;
    localparam int WIN    = 4;

    typedef logic signed [DATA_W-1:0] pix_t;
    typedef pix_t win_t [0:WIN-1];

endpackage : pool_pkg
`default_nettype wire

// File: rtl/pool_pair.sv
`default_nettype none
// ============================================================================
//  Module      : pool_pair
//  Description : Combinational 2-input reducer used by both pooling stages.
//                Default build: y = sign-extended a + b.
//                POOL_MAX_EN  : y = sign-extended signed max(a, b).
//  Ports       : a, b  in  [IN_W-1:0] signed   operands
//                y     out [IN_W:0]   signed   reduced result, one bit wider
//  Build macro : POOL_MAX_EN
//  Revision    : 1.0  initial release
// ============================================================================
module pool_pair
    import pool_pkg::*;
#(
    parameter int IN_W = 16
) (
    input  logic signed [IN_W-1:0] a,
    input  logic signed [IN_W-1:0] b,
    output logic signed [IN_W:0]   y
);

`ifdef POOL_MAX_EN
    // Output is kept one bit wider so both build modes share one pipeline
    // datapath; ties pick a (operands are equal anyway).
    assign y = (a >= b) ? {a[IN_W-1], a} : {b[IN_W-1], b};
`else
    assign y = {a[IN_W-1], a} + {b[IN_W-1], b};
`endif

endmodule : pool_pair
`default_nettype wire

// File: rtl/pool_window.sv
`default_nettype none
// ============================================================================
//  Module      : pool_window
//  Description : 2x2 pooling element, two-stage pipeline, one window/cycle.
//                Default build averages the four pixels (floor rounding);
//                POOL_MAX_EN selects max pooling. Latency is 2 cycles.
//  Ports       : clk        in   rising-edge clock
//                rst        in   asynchronous active-high reset
//                in_valid   in   window valid this cycle
//                window     in   [0:WIN-1][DATA_W-1:0] pixels TL,TR,BL,BR
//                out_valid  out  value valid this cycle
//                value      out  [DATA_W-1:0] signed pooled pixel
//  Build macro : POOL_MAX_EN
//  Revision    : 1.0  initial release
// ============================================================================
module pool_window #(
    parameter int DATA_W = pool_pkg::DATA_W,
    parameter int WIN    = pool_pkg::WIN
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic signed [0:WIN-1][DATA_W-1:0] window,
    output logic                            out_valid,
    output logic signed [DATA_W-1:0]        value
);

    import pool_pkg::*;

    // The datapath is hard-wired for a 2x2 window.
    generate
        if (WIN != 4) begin : g_win_check
            $error("pool_window supports WIN == 4 only");
        end
    endgenerate

    // ---------------- stage 1: pairwise reduction ----------------
    logic signed [DATA_W:0] w_top;
    logic signed [DATA_W:0] w_bot;
    logic signed [DATA_W:0] r_s0;
    logic signed [DATA_W:0] r_s1;
    logic                   r_v1;

    pool_pair #(.IN_W(DATA_W)) u_pair_top (
        .a (window[0]),
        .b (window[1]),
        .y (w_top)
    );

    pool_pair #(.IN_W(DATA_W)) u_pair_bot (
        .a (window[2]),
        .b (window[3]),
        .y (w_bot)
    );

    // Data registers only load on a valid window; the valid bit always moves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0 <= '0;
            r_s1 <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_s0 <= w_top;
                r_s1 <= w_bot;
            end
        end
    end

    // ---------------- stage 2: final reduction ----------------
    logic signed [DATA_W+1:0] w_red;
    logic signed [DATA_W-1:0] w_pool;
    logic        [1:0]        w_unused_bits;

    pool_pair #(.IN_W(DATA_W+1)) u_pair_fin (
        .a (r_s0),
        .b (r_s1),
        .y (w_red)
    );

`ifdef POOL_MAX_EN
    // Max of sign-extended pixels always fits back into DATA_W bits.
    assign w_pool        = w_red[DATA_W-1:0];
    assign w_unused_bits = w_red[DATA_W+1:DATA_W];
`else
    // Dropping the two LSBs of a signed sum is an arithmetic shift by 2,
    // i.e. divide by 4 rounding toward -inf; the quotient fits DATA_W bits.
    assign w_pool        = w_red[DATA_W+1:2];
    assign w_unused_bits = w_red[1:0];
`endif

    // value holds its last result while no new window arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            value     <= '0;
        end else begin
            out_valid <= r_v1;
            if (r_v1) begin
                value <= w_pool;
            end
        end
    end

endmodule : pool_window
`default_nettype wire

// File: tb/tb_pool_window.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pool_window
//  Description : Directed self-checking bench for pool_window. Expected
//                values are hand-computed for both the average build and
//                the POOL_MAX_EN build.
//  Build macro : POOL_MAX_EN
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pool_window;

    localparam int DW = 16;

    logic                      clk;
    logic                      rst;
    logic                      in_valid;
    logic signed [0:3][DW-1:0] window;
    logic                      out_valid;
    logic signed [DW-1:0]      value;

    int vectors;
    int miscompares;

    pool_window #(.DATA_W(DW), .WIN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .window    (window),
        .out_valid (out_valid),
        .value     (value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c, input logic [DW-1:0] d);
        in_valid  = 1'b1;
        window[0] = a;
        window[1] = b;
        window[2] = c;
        window[3] = d;
    endtask

    // One isolated window: out_valid must be low one cycle later and carry
    // the result two cycles later.
    task automatic single(input string tag,
                          input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] c, input logic [DW-1:0] d,
                          input logic [DW-1:0] exp);
        @(negedge clk);
        drive(a, b, c, d);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_lat1_valid"}, {15'd0, out_valid}, 16'd0);
        @(negedge clk);
        check({tag, "_valid"}, {15'd0, out_valid}, 16'd1);
        check({tag, "_value"}, value, exp);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        window      = '0;

        repeat (2) @(negedge clk);
        check("reset_valid", {15'd0, out_valid}, 16'd0);
        check("reset_value", value, 16'h0000);
        rst = 1'b0;

`ifdef POOL_MAX_EN
        single("ones",   16'h0400, 16'h0400, 16'h0400, 16'h0400, 16'h0400);
        single("mixed",  16'h0800, 16'h0C00, 16'hFC00, 16'hF000, 16'h0C00);
        single("neg",    16'h3400, 16'h1400, 16'h8400, 16'h0700, 16'h3400);
        single("rnd_m1", 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        single("rnd_3",  16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0001);
`else
        single("ones",   16'h0400, 16'h0400, 16'h0400, 16'h0400, 16'h0400);
        single("mixed",  16'h0800, 16'h0C00, 16'hFC00, 16'hF000, 16'h0000);
        single("neg",    16'h3400, 16'h1400, 16'h8400, 16'h0700, 16'hF4C0);
        single("rnd_m1", 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF);
        single("rnd_3",  16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0000);
`endif
        single("min",    16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
        single("max",    16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);

        // Back-to-back windows on consecutive cycles.
        @(negedge clk);
        drive(16'h2400, 16'h0430, 16'h1400, 16'h0400);
        @(negedge clk);
        drive(16'h5000, 16'h5800, 16'h6000, 16'h6800);
        check("b2b_pre_valid", {15'd0, out_valid}, 16'd0);
        @(negedge clk);
        drive(16'hB000, 16'hA800, 16'hA000, 16'h9800);
        check("b2b0_valid", {15'd0, out_valid}, 16'd1);
`ifdef POOL_MAX_EN
        check("b2b0_value", value, 16'h2400);
`else
        check("b2b0_value", value, 16'h100C);
`endif
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b1_valid", {15'd0, out_valid}, 16'd1);
`ifdef POOL_MAX_EN
        check("b2b1_value", value, 16'h6800);
`else
        check("b2b1_value", value, 16'h5C00);
`endif
        @(negedge clk);
        check("b2b2_valid", {15'd0, out_valid}, 16'd1);
`ifdef POOL_MAX_EN
        check("b2b2_value", value, 16'hB000);
`else
        check("b2b2_value", value, 16'hA400);
`endif
        @(negedge clk);
        check("b2b_post_valid", {15'd0, out_valid}, 16'd0);
`ifdef POOL_MAX_EN
        check("hold_value", value, 16'hB000);
`else
        check("hold_value", value, 16'hA400);
`endif

        // Asynchronous reset while a window sits in stage 1.
        @(negedge clk);
        drive(16'h0400, 16'h0400, 16'h0400, 16'h0400);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("arst_valid", {15'd0, out_valid}, 16'd0);
        check("arst_value", value, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_quiet", {15'd0, out_valid}, 16'd0);
        end
        check("post_rst_value", value, 16'h0000);

        // Pipeline resumes cleanly after reset.
        single("resume", 16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0800);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #20000;
        $display("FAIL timeout: observed no finish, expected finish before 20000");
        $fatal(1, "timeout");
    end

endmodule : tb_pool_window
`default_nettype wire
